// File: rtl/countdown_sequencer_pkg.sv
// countdown_pkg: shared state enum and default sizing for countdown_sequencer.
// No ports; imported by the interface, prescaler and sequencer.
package countdown_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_TICK_DIV   = 4;
  localparam int DEF_PRESCALE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    HALVE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/countdown_sequencer_if.sv
// countdown_sequencer_if: command/status and counter-side signals.
// master = control/counter side, slave = sequencer (start..cnt_in in, ld_val..done out).
interface countdown_sequencer_if
  import countdown_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic              abort;
  logic [DATA_W-1:0] load_val;
  logic              halve_req;
  logic [DATA_W-1:0] cnt_in;
  logic [DATA_W-1:0] ld_val;
  logic              latch;
  logic              dec;
  logic              div;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, load_val, halve_req, cnt_in,
    input  ld_val, latch, dec, div, busy, done
  );

  modport slave (
    input  start, abort, load_val, halve_req, cnt_in,
    output ld_val, latch, dec, div, busy, done
  );

endinterface

// File: rtl/countdown_sequencer_prescaler.sv
// tick_prescaler: modulo-TICK_DIV counter; tick is a registered one-cycle pulse.
// Ports: clk, reset (async high), clr (sync clear), en (advance), tick.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] LAST =
    PRESCALE_W'(TICK_DIV - 1);
  localparam logic [PRESCALE_W-1:0] PRE =
    PRESCALE_W'(TICK_DIV - 2);

  logic [PRESCALE_W-1:0] cnt;

  // tick fires on the advance that lands on LAST, so
  // the first pulse comes TICK_DIV-1 advances after a clear
  // and the period afterwards is TICK_DIV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == PRE);
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: start/abort FSM driving counter latch/dec/div, reports done.
// Ports: clk, reset (async high), io (slave). Option: COUNTDOWN_SEQ_AUTO_RELOAD_EN.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  countdown_sequencer_if.slave  io
);

  seq_state_t        state;
  seq_state_t        nxt;
  logic [DATA_W-1:0] ld_q;
  logic [DATA_W-1:0] ld_d;
  logic              latch_q;
  logic              div_q;
  logic              busy_q;
  logic              done_q;
  logic              latch_d;
  logic              div_d;
  logic              busy_d;
  logic              done_d;
  logic              run_go;
  logic              tick;

  // Prescaler only advances on a RUN cycle that stays
  // in RUN; any other state clears it.
  assign run_go = (state == RUN) && !io.abort &&
                  (io.cnt_in != '0) && !io.halve_req;

  tick_prescaler #(
    .TICK_DIV   (TICK_DIV),
    .PRESCALE_W (PRESCALE_W)
  ) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   (state != RUN),
    .en    (run_go),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (io.start && !io.abort) nxt = LOAD;
      end
      LOAD: begin
        nxt = io.abort ? IDLE : RUN;
      end
      RUN: begin
        unique case (1'b1)
          io.abort:         nxt = IDLE;
          (io.cnt_in == '0): nxt = DONE;
          io.halve_req:     nxt = HALVE;
          default:          nxt = RUN;
        endcase
      end
      HALVE: begin
        nxt = io.abort ? IDLE : RUN;
      end
      DONE: begin
`ifdef COUNTDOWN_SEQ_AUTO_RELOAD_EN
        nxt = io.abort ? IDLE : LOAD;
`else
        nxt = IDLE;
`endif
      end
      default: nxt = IDLE;
    endcase
  end

  // Strobes are registered decodes of the next state, so
  // each is high exactly while the FSM sits in its state.
  always_comb begin
    latch_d = (nxt == LOAD);
    div_d   = (nxt == HALVE);
    done_d  = (nxt == DONE);
    busy_d  = (nxt != IDLE);
    ld_d    = ld_q;
    if (state == IDLE && nxt == LOAD) ld_d = io.load_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_q    <= '0;
      latch_q <= 1'b0;
      div_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ld_q    <= ld_d;
      latch_q <= latch_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io.ld_val = ld_q;
  assign io.latch  = latch_q;
  assign io.dec    = tick;
  assign io.div    = div_q;
  assign io.busy   = busy_q;
  assign io.done   = done_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed table plus corner sequences with a counter model.
// Ports: none. Honours COUNTDOWN_SEQ_AUTO_RELOAD_EN for the reload checks.
module tb_countdown_sequencer;
  import countdown_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  countdown_sequencer_if #(.DATA_W(8)) ifc ();

  countdown_sequencer #(
    .DATA_W     (8),
    .TICK_DIV   (4),
    .PRESCALE_W (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (ifc.slave)
  );

  logic [7:0] cnt;
  always @(posedge clk or posedge reset) begin
    if (reset)          cnt <= 8'd0;
    else if (ifc.latch) cnt <= ifc.ld_val;
    else if (ifc.dec)   cnt <= cnt - 8'd1;
    else if (ifc.div)   cnt <= cnt >> 1;
  end
  assign ifc.cnt_in = cnt;

  int n_latch = 0;
  int n_dec   = 0;
  int n_div   = 0;
  int n_done  = 0;
  always @(negedge clk) begin
    if (ifc.latch) n_latch++;
    if (ifc.dec)   n_dec++;
    if (ifc.div)   n_div++;
    if (ifc.done)  n_done++;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start;
    logic [7:0] load_val;
    logic [4:0] o;
    logic [7:0] ld;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic s, logic [7:0] lv,
                              logic [4:0] o, logic [7:0] ld);
    vec_t v;
    v.start    = s;
    v.load_val = lv;
    v.o        = o;
    v.ld       = ld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (ifc.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  function automatic logic [4:0] outs();
    return {ifc.latch, ifc.dec, ifc.div, ifc.busy, ifc.done};
  endfunction

  int snap;

  initial begin
    // o = {latch, dec, div, busy, done}
    tbl[0]  = mk(1'b1, 8'd3, 5'b10010, 8'd3);
    tbl[1]  = mk(1'b0, 8'd0, 5'b00010, 8'd3);
    tbl[2]  = mk(1'b1, 8'd7, 5'b00010, 8'd3);
    tbl[3]  = mk(1'b0, 8'd0, 5'b00010, 8'd3);
    tbl[4]  = mk(1'b0, 8'd0, 5'b01010, 8'd3);
    tbl[5]  = mk(1'b0, 8'd0, 5'b00010, 8'd3);
    tbl[6]  = mk(1'b0, 8'd0, 5'b00010, 8'd3);
    tbl[7]  = mk(1'b0, 8'd0, 5'b00010, 8'd3);
    tbl[8]  = mk(1'b0, 8'd0, 5'b01010, 8'd3);
    tbl[9]  = mk(1'b0, 8'd0, 5'b00010, 8'd3);
    tbl[10] = mk(1'b0, 8'd0, 5'b00010, 8'd3);
    tbl[11] = mk(1'b0, 8'd0, 5'b00010, 8'd3);
    tbl[12] = mk(1'b0, 8'd0, 5'b01010, 8'd3);
    tbl[13] = mk(1'b0, 8'd0, 5'b00010, 8'd3);
    tbl[14] = mk(1'b0, 8'd0, 5'b00011, 8'd3);
    tbl[15] = mk(1'b1, 8'd9, 5'b00000, 8'd3);
    tbl[16] = mk(1'b0, 8'd0, 5'b00000, 8'd3);
    tbl[17] = mk(1'b1, 8'd0, 5'b10010, 8'd0);
    tbl[18] = mk(1'b0, 8'd0, 5'b00010, 8'd0);
    tbl[19] = mk(1'b0, 8'd0, 5'b00011, 8'd0);
    tbl[20] = mk(1'b0, 8'd0, 5'b00000, 8'd0);

    reset         = 1'b1;
    ifc.start     = 1'b0;
    ifc.abort     = 1'b0;
    ifc.load_val  = 8'd0;
    ifc.halve_req = 1'b0;
    #12;
    chk("reset_outs", {outs(), ifc.ld_val}, 32'd0);
    #8;
    reset = 1'b0;
    cyc();

`ifndef COUNTDOWN_SEQ_AUTO_RELOAD_EN
    for (int i = 0; i < 21; i++) begin
      ifc.start    = tbl[i].start;
      ifc.load_val = tbl[i].load_val;
      cyc();
      chk($sformatf("tbl_%0d", i),
          {outs(), ifc.ld_val}, {tbl[i].o, tbl[i].ld});
    end
    ifc.start = 1'b0;
`endif

    // halve after the first decrement
    ifc.start    = 1'b1;
    ifc.load_val = 8'd100;
    cyc();
    ifc.start = 1'b0;
    repeat (5) cyc();
    chk("halve_pre_cnt", ifc.cnt_in, 32'd99);
    ifc.halve_req = 1'b1;
    cyc();
    chk("halve_div", ifc.div, 32'd1);
    ifc.halve_req = 1'b0;
    cyc();
    chk("halve_div_off", ifc.div, 32'd0);
    chk("halve_cnt", ifc.cnt_in, 32'd49);
    for (int k = 8; k <= 10; k++) begin
      cyc();
      chk($sformatf("halve_dec_%0d", k), ifc.dec,
          32'(k == 10));
    end
    cyc();
    chk("halve_cnt_after_dec", ifc.cnt_in, 32'd48);
    ifc.abort = 1'b1;
    cyc();
    ifc.abort = 1'b0;
    chk("halve_abort_busy", ifc.busy, 32'd0);

    // abort mid-run, then restart
    ifc.start    = 1'b1;
    ifc.load_val = 8'd10;
    cyc();
    ifc.start = 1'b0;
    repeat (6) cyc();
    chk("abort_pre_busy", ifc.busy, 32'd1);
    ifc.abort = 1'b1;
    cyc();
    ifc.abort = 1'b0;
    chk("abort_busy_done", {ifc.busy, ifc.done}, 32'd0);
    snap = n_latch + n_dec + n_div + n_done;
    repeat (10) cyc();
    chk("abort_quiet", n_latch + n_dec + n_div + n_done, snap);
    ifc.start    = 1'b1;
    ifc.load_val = 8'd2;
    cyc();
    ifc.start = 1'b0;
    chk("restart_latch", {ifc.latch, ifc.ld_val}, {1'b1, 8'd2});
    snap = n_dec;
    wait_done("restart_done");
    chk("restart_decs", n_dec - snap, 32'd2);
`ifndef COUNTDOWN_SEQ_AUTO_RELOAD_EN
    cyc();
    chk("restart_idle", ifc.busy, 32'd0);
`else
    ifc.abort = 1'b1;
    cyc();
    ifc.abort = 1'b0;
`endif

    // asynchronous reset between edges
    ifc.start    = 1'b1;
    ifc.load_val = 8'd5;
    cyc();
    ifc.start = 1'b0;
    repeat (6) cyc();
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outs", {outs(), ifc.ld_val}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    ifc.start    = 1'b1;
    ifc.load_val = 8'd1;
    cyc();
    ifc.start = 1'b0;
    chk("post_reset_latch", {ifc.latch, ifc.ld_val},
        {1'b1, 8'd1});
    snap = n_dec;
    wait_done("post_reset_done");
    chk("post_reset_decs", n_dec - snap, 32'd1);
`ifndef COUNTDOWN_SEQ_AUTO_RELOAD_EN
    cyc();
    chk("post_reset_idle", ifc.busy, 32'd0);
`else
    ifc.abort = 1'b1;
    cyc();
    ifc.abort = 1'b0;

    // periodic reload until abort
    ifc.start    = 1'b1;
    ifc.load_val = 8'd2;
    cyc();
    ifc.start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_done($sformatf("reload_done_%0d", r));
      cyc();
      chk($sformatf("reload_latch_%0d", r),
          {ifc.latch, ifc.ld_val, ifc.busy},
          {1'b1, 8'd2, 1'b1});
    end
    ifc.abort = 1'b1;
    cyc();
    ifc.abort = 1'b0;
    chk("reload_abort_busy", ifc.busy, 32'd0);
    snap = n_done;
    repeat (20) cyc();
    chk("reload_stopped", n_done - snap, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
